// File: rtl/spatz_vlsu_addrgen.sv
// -----------------------------------------------------------------------------
// spatz_vlsu_addrgen
//
// Address/request generator for the Spatz vector load/store unit. Takes one
// decoded VLE/VSE/VLSE operation at a time and turns it into a stream of
// ELEN-wide memory requests. Each operation ends with a one-cycle
// done/exception pulse back to the controller.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   operation handshake (ready only while idle)
//   req_id_i                    instruction ID
//   req_base_i, req_stride_i    base byte address, byte stride (strided only)
//   req_strided_i               1 = strided, 0 = unit-stride
//   req_is_load_i               1 = load, 0 = store
//   req_ew_i                    element width, log2 bytes (0..3)
//   req_vl_i, req_vstart_i      vector length, start element
//   mem_valid_o / mem_ready_i   memory request handshake
//   mem_addr_o, mem_we_o        request address, write enable
//   mem_strb_o, mem_size_o      byte strobes, log2 access bytes
//   mem_last_o, mem_id_o        last beat of the operation, instruction ID
//   done_valid_o, done_id_o     one-cycle completion pulse and its ID
//   done_exc_o                  operation rejected (no or partial traffic)
//   busy_o                      an operation is in flight
//
// Configuration
//   SPATZ_LSU_STRIDED_EN        define to build the strided path; without it
//                               every strided request completes with an
//                               exception and issues no memory traffic.
//
// All mem_* and done_* outputs come straight from flops; req_ready_o and
// busy_o decode the state register.
// -----------------------------------------------------------------------------
module spatz_vlsu_addrgen #(
    parameter int unsigned ELEN    = 32,
    parameter int unsigned MAXVL   = 256,
    parameter int unsigned IdWidth = 2,
    parameter int unsigned VlWidth = $clog2(MAXVL + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [IdWidth-1:0] req_id_i,
    input  logic [31:0]        req_base_i,
    input  logic [31:0]        req_stride_i,
    input  logic               req_strided_i,
    input  logic               req_is_load_i,
    input  logic [1:0]         req_ew_i,
    input  logic [VlWidth-1:0] req_vl_i,
    input  logic [VlWidth-1:0] req_vstart_i,
    output logic               mem_valid_o,
    input  logic               mem_ready_i,
    output logic [31:0]        mem_addr_o,
    output logic               mem_we_o,
    output logic [ELEN/8-1:0]  mem_strb_o,
    output logic [1:0]         mem_size_o,
    output logic               mem_last_o,
    output logic [IdWidth-1:0] mem_id_o,
    output logic               done_valid_o,
    output logic [IdWidth-1:0] done_id_o,
    output logic               done_exc_o,
    output logic               busy_o
);

    localparam int unsigned ELENB = ELEN / 8;
    localparam int unsigned OffW  = $clog2(ELENB);

`ifdef SPATZ_LSU_STRIDED_EN
    localparam bit StridedEn = 1'b1;
`else
    localparam bit StridedEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    // Everything needed to present one beat and to advance past it.
    typedef struct packed {
        logic [31:0]        addr;
        logic [ELENB-1:0]   strb;
        logic [1:0]         size;
        logic               last;
        logic               misaligned;
        logic [31:0]        adv;    // bytes to add to cur_addr after the beat
        logic [VlWidth-1:0] elems;  // elements consumed by the beat
    } beat_t;

    // Low address bits that must be zero for an element of width ew.
    function automatic logic [OffW-1:0] low_mask(input logic [1:0] ew);
        logic [OffW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < OffW; i++) m[i] = (i < 32'(ew));
        return m;
    endfunction

    function automatic beat_t calc_beat(input logic [31:0]        addr,
                                        input logic [VlWidth-1:0] rem,
                                        input logic [1:0]         ew,
                                        input logic               strided,
                                        input logic [31:0]        stride);
        beat_t       b;
        int unsigned off;
        int unsigned esz;
        int unsigned rem_bytes;
        int unsigned avail;
        int unsigned nbytes;
        b         = '0;
        off       = 32'(addr[OffW-1:0]);
        esz       = 32'd1 << ew;
        rem_bytes = 32'(rem) << ew;
        avail     = ELENB - off;
        if (strided) begin
            b.addr = addr;
            for (int unsigned i = 0; i < ELENB; i++) b.strb[i] = (i >= off) && (i < off + esz);
            b.size       = ew;
            b.last       = (rem == VlWidth'(1));
            b.misaligned = |(addr[OffW-1:0] & low_mask(ew));
            b.adv        = stride;
            b.elems      = VlWidth'(1);
        end else begin
            // Fill the rest of the current word, or stop early on the tail.
            nbytes = (rem_bytes < avail) ? rem_bytes : avail;
            b.addr = {addr[31:OffW], OffW'(0)};
            for (int unsigned i = 0; i < ELENB; i++) b.strb[i] = (i >= off) && (i < off + nbytes);
            b.size  = 2'(OffW);
            b.last  = (rem_bytes <= avail);
            b.adv   = nbytes;
            b.elems = VlWidth'(nbytes >> ew);
        end
        return b;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        cur_addr_q, cur_addr_d;
    logic [31:0]        stride_q, stride_d;
    logic [31:0]        adv_q, adv_d;
    logic [VlWidth-1:0] remaining_q, remaining_d;
    logic [VlWidth-1:0] elems_q, elems_d;
    logic [1:0]         ew_q, ew_d;
    logic               strided_q, strided_d;

    logic               mem_valid_d, mem_we_d, mem_last_d;
    logic [31:0]        mem_addr_d;
    logic [ELENB-1:0]   mem_strb_d;
    logic [1:0]         mem_size_d;
    logic [IdWidth-1:0] mem_id_d, done_id_d;
    logic               done_valid_d, done_exc_d;

    logic               load_beat, finish, finish_exc, reject;
    logic [31:0]        beat_addr, beat_stride;
    logic [VlWidth-1:0] beat_rem;
    logic [1:0]         beat_ew;
    logic               beat_strided;
    beat_t              beat;

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        stride_d     = stride_q;
        adv_d        = adv_q;
        remaining_d  = remaining_q;
        elems_d      = elems_q;
        ew_d         = ew_q;
        strided_d    = strided_q;
        mem_valid_d  = mem_valid_o;
        mem_we_d     = mem_we_o;
        mem_last_d   = mem_last_o;
        mem_addr_d   = mem_addr_o;
        mem_strb_d   = mem_strb_o;
        mem_size_d   = mem_size_o;
        mem_id_d     = mem_id_o;
        done_id_d    = done_id_o;
        done_valid_d = 1'b0;
        done_exc_d   = 1'b0;
        load_beat    = 1'b0;
        finish       = 1'b0;
        finish_exc   = 1'b0;
        reject       = 1'b0;
        beat_addr    = cur_addr_q;
        beat_rem     = remaining_q;
        beat_ew      = ew_q;
        beat_strided = strided_q;
        beat_stride  = stride_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    ew_d      = req_ew_i;
                    stride_d  = req_stride_i;
                    strided_d = StridedEn && req_strided_i;
                    mem_we_d  = !req_is_load_i;
                    mem_id_d  = req_id_i;
                    if (strided_d) cur_addr_d = req_base_i + req_stride_i * 32'(req_vstart_i);
                    else           cur_addr_d = req_base_i + (32'(req_vstart_i) << req_ew_i);
                    remaining_d = req_vl_i - req_vstart_i;
                    reject = (req_strided_i && !StridedEn) || (32'(req_ew_i) > OffW)
                             || |(req_base_i[OffW-1:0] & low_mask(req_ew_i));
                    if (reject) begin
                        finish     = 1'b1;
                        finish_exc = 1'b1;
                    end else if (req_vstart_i >= req_vl_i) begin
                        finish = 1'b1;
                    end else begin
                        load_beat    = 1'b1;
                        beat_addr    = cur_addr_d;
                        beat_rem     = remaining_d;
                        beat_ew      = req_ew_i;
                        beat_strided = strided_d;
                        beat_stride  = req_stride_i;
                    end
                end
            end
            ISSUE: begin
                if (mem_valid_o && mem_ready_i) begin
                    if (mem_last_o) begin
                        finish = 1'b1;
                    end else begin
                        cur_addr_d  = cur_addr_q + adv_q;
                        remaining_d = remaining_q - elems_q;
                        load_beat   = 1'b1;
                        beat_addr   = cur_addr_d;
                        beat_rem    = remaining_d;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Next beat is prepared here so the outputs are registered; a
        // misaligned strided element ends the operation instead of issuing.
        beat = calc_beat(beat_addr, beat_rem, beat_ew, beat_strided, beat_stride);
        if (load_beat && beat.misaligned) begin
            finish     = 1'b1;
            finish_exc = 1'b1;
        end else if (load_beat) begin
            state_d     = ISSUE;
            mem_valid_d = 1'b1;
            mem_addr_d  = beat.addr;
            mem_strb_d  = beat.strb;
            mem_size_d  = beat.size;
            mem_last_d  = beat.last;
            adv_d       = beat.adv;
            elems_d     = beat.elems;
        end

        if (finish) begin
            state_d      = DONE;
            mem_valid_d  = 1'b0;
            mem_last_d   = 1'b0;
            done_valid_d = 1'b1;
            done_exc_d   = finish_exc;
            done_id_d    = mem_id_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            stride_q     <= '0;
            adv_q        <= '0;
            remaining_q  <= '0;
            elems_q      <= '0;
            ew_q         <= '0;
            strided_q    <= 1'b0;
            mem_valid_o  <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_last_o   <= 1'b0;
            mem_addr_o   <= '0;
            mem_strb_o   <= '0;
            mem_size_o   <= '0;
            mem_id_o     <= '0;
            done_valid_o <= 1'b0;
            done_id_o    <= '0;
            done_exc_o   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            stride_q     <= stride_d;
            adv_q        <= adv_d;
            remaining_q  <= remaining_d;
            elems_q      <= elems_d;
            ew_q         <= ew_d;
            strided_q    <= strided_d;
            mem_valid_o  <= mem_valid_d;
            mem_we_o     <= mem_we_d;
            mem_last_o   <= mem_last_d;
            mem_addr_o   <= mem_addr_d;
            mem_strb_o   <= mem_strb_d;
            mem_size_o   <= mem_size_d;
            mem_id_o     <= mem_id_d;
            done_valid_o <= done_valid_d;
            done_id_o    <= done_id_d;
            done_exc_o   <= done_exc_d;
        end
    end

endmodule

// File: tb/tb_spatz_vlsu_addrgen.sv
// -----------------------------------------------------------------------------
// tb_spatz_vlsu_addrgen
//
// Self-checking bench for spatz_vlsu_addrgen. Each operation is expanded by a
// reference model into the list of memory beats it must produce: unit-stride
// operations are walked byte by byte and grouped into ELEN words, strided
// operations element by element. The DUT's beats are compared in order, and
// the done pulse, its timing and its exception flag are checked afterwards.
// Honors SPATZ_LSU_STRIDED_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_spatz_vlsu_addrgen;

    localparam int IdWidth = 2;
    localparam int VlWidth = 9;

`ifdef SPATZ_LSU_STRIDED_EN
    localparam bit StridedEn = 1'b1;
`else
    localparam bit StridedEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]        base;
        logic [31:0]        stride;
        logic               strided;
        logic               is_load;
        logic [1:0]         ew;
        logic [VlWidth-1:0] vl;
        logic [VlWidth-1:0] vstart;
        logic [IdWidth-1:0] id;
    } op_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [1:0]  size;
        logic        last;
    } exp_beat_t;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [IdWidth-1:0] req_id_i;
    logic [31:0]        req_base_i;
    logic [31:0]        req_stride_i;
    logic               req_strided_i;
    logic               req_is_load_i;
    logic [1:0]         req_ew_i;
    logic [VlWidth-1:0] req_vl_i;
    logic [VlWidth-1:0] req_vstart_i;
    logic               mem_valid_o;
    logic               mem_ready_i;
    logic [31:0]        mem_addr_o;
    logic               mem_we_o;
    logic [3:0]         mem_strb_o;
    logic [1:0]         mem_size_o;
    logic               mem_last_o;
    logic [IdWidth-1:0] mem_id_o;
    logic               done_valid_o;
    logic [IdWidth-1:0] done_id_o;
    logic               done_exc_o;
    logic               busy_o;

    int n_checks = 0;
    int n_errors = 0;

    exp_beat_t exp_q[$];
    bit        exp_exc;

    always #5 clk_i = ~clk_i;

    spatz_vlsu_addrgen dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_id_i      (req_id_i),
        .req_base_i    (req_base_i),
        .req_stride_i  (req_stride_i),
        .req_strided_i (req_strided_i),
        .req_is_load_i (req_is_load_i),
        .req_ew_i      (req_ew_i),
        .req_vl_i      (req_vl_i),
        .req_vstart_i  (req_vstart_i),
        .mem_valid_o   (mem_valid_o),
        .mem_ready_i   (mem_ready_i),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_strb_o    (mem_strb_o),
        .mem_size_o    (mem_size_o),
        .mem_last_o    (mem_last_o),
        .mem_id_o      (mem_id_o),
        .done_valid_o  (done_valid_o),
        .done_id_o     (done_id_o),
        .done_exc_o    (done_exc_o),
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic op_t make_op(input logic [31:0] base, input logic [31:0] stride,
                                    input logic strided, input logic is_load, input logic [1:0] ew,
                                    input int vl, input int vstart, input int id);
        op_t op;
        op.base    = base;
        op.stride  = stride;
        op.strided = strided;
        op.is_load = is_load;
        op.ew      = ew;
        op.vl      = VlWidth'(vl);
        op.vstart  = VlWidth'(vstart);
        op.id      = IdWidth'(id);
        return op;
    endfunction

    // Reference model: expected beats and exception flag for one operation.
    task automatic build_expected(input op_t op);
        exp_beat_t   cur;
        bit          have;
        logic [31:0] esz, a, b;
        int          total;
        exp_q.delete();
        exp_exc = 1'b0;
        cur     = '0;
        esz     = 32'd1 << op.ew;
        if ((op.strided && !StridedEn) || op.ew > 2'd2 || (op.base % esz) != 0) begin
            exp_exc = 1'b1;
            return;
        end
        if (op.vstart >= op.vl) return;
        if (op.strided) begin
            for (int e = int'(op.vstart); e < int'(op.vl); e++) begin
                a = op.base + op.stride * 32'(e);
                if ((a % esz) != 0) begin
                    exp_exc = 1'b1;
                    return;
                end
                cur.addr = a;
                cur.strb = 4'(((32'd1 << esz) - 32'd1) << a[1:0]);
                cur.size = op.ew;
                cur.last = (e == int'(op.vl) - 1);
                exp_q.push_back(cur);
            end
        end else begin
            a     = op.base + 32'(op.vstart) * esz;
            total = int'(op.vl - op.vstart) * int'(esz);
            have  = 1'b0;
            for (int k = 0; k < total; k++) begin
                b = a + 32'(k);
                if (have && cur.addr != {b[31:2], 2'b00}) begin
                    exp_q.push_back(cur);
                    have = 1'b0;
                end
                if (!have) begin
                    cur  = '0;
                    cur.addr = {b[31:2], 2'b00};
                    cur.size = 2'd2;
                    have = 1'b1;
                end
                cur.strb[b[1:0]] = 1'b1;
            end
            cur.last = 1'b1;
            exp_q.push_back(cur);
        end
    endtask

    task automatic apply_req(input op_t op);
        req_valid_i   = 1'b1;
        req_id_i      = op.id;
        req_base_i    = op.base;
        req_stride_i  = op.stride;
        req_strided_i = op.strided;
        req_is_load_i = op.is_load;
        req_ew_i      = op.ew;
        req_vl_i      = op.vl;
        req_vstart_i  = op.vstart;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},  req_ready_o,  1);
        check({pfx, "_busy"},       busy_o,       0);
        check({pfx, "_mem_valid"},  mem_valid_o,  0);
        check({pfx, "_mem_last"},   mem_last_o,   0);
        check({pfx, "_mem_we"},     mem_we_o,     0);
        check({pfx, "_mem_addr"},   mem_addr_o,   0);
        check({pfx, "_mem_strb"},   mem_strb_o,   0);
        check({pfx, "_mem_size"},   mem_size_o,   0);
        check({pfx, "_mem_id"},     mem_id_o,     0);
        check({pfx, "_done_valid"}, done_valid_o, 0);
        check({pfx, "_done_exc"},   done_exc_o,   0);
        check({pfx, "_done_id"},    done_id_o,    0);
    endtask

    // mode 0: memory always ready; 1: random ready; 2: ready low for three
    // cycles on the second beat, otherwise high. Called at a negedge, idle.
    task automatic run_op(input op_t op, input int mode);
        exp_beat_t e;
        int        cycles;
        int        beat_idx;
        int        stall_left;
        bit        done_seen;
        build_expected(op);
        check("req_ready_idle", req_ready_o, 1);
        apply_req(op);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cycles     = 0;
        beat_idx   = 0;
        stall_left = 3;
        done_seen  = 1'b0;
        while (!done_seen && cycles < 100) begin
            mem_ready_i = 1'b0;
            if (done_valid_o) begin
                check("done_beats_left", exp_q.size(), 0);
                check("done_id", done_id_o, op.id);
                check("done_exc", done_exc_o, exp_exc);
                check("done_mem_valid", mem_valid_o, 0);
                done_seen = 1'b1;
            end else if (mem_valid_o && exp_q.size() > 0) begin
                e = exp_q[0];
                check("mem_addr", mem_addr_o, e.addr);
                check("mem_strb", mem_strb_o, e.strb);
                check("mem_size", mem_size_o, e.size);
                check("mem_last", mem_last_o, e.last);
                check("mem_we", mem_we_o, !op.is_load);
                check("mem_id", mem_id_o, op.id);
                check("busy", busy_o, 1);
                case (mode)
                    0: mem_ready_i = 1'b1;
                    1: mem_ready_i = 1'($urandom_range(0, 1));
                    default: begin
                        if (beat_idx == 1 && stall_left > 0) stall_left--;
                        else mem_ready_i = 1'b1;
                    end
                endcase
                if (mem_ready_i) begin
                    void'(exp_q.pop_front());
                    beat_idx++;
                end
            end else begin
                check("cycle_activity", {30'b0, mem_valid_o, done_valid_o},
                      (exp_q.size() > 0) ? 32'd2 : 32'd1);
            end
            @(posedge clk_i);
            @(negedge clk_i);
            cycles++;
        end
        mem_ready_i = 1'b0;
        check("done_seen", done_seen, 1);
        if (done_seen) begin
            check("done_one_cycle", done_valid_o, 0);
            check("ready_after_done", req_ready_o, 1);
            check("idle_after_done", busy_o, 0);
        end
    endtask

    initial begin
        op_t         op;
        logic [31:0] esz;
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_id_i      = '0;
        req_base_i    = '0;
        req_stride_i  = '0;
        req_strided_i = 1'b0;
        req_is_load_i = 1'b0;
        req_ew_i      = '0;
        req_vl_i      = '0;
        req_vstart_i  = '0;
        mem_ready_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Unit-stride word load: 0x1000/04/08/0C, strb 0xF.
        run_op(make_op(32'h0000_1000, 32'h0, 1'b0, 1'b1, 2'd2, 4, 0, 1), 0);
        // Unaligned byte store: 0x1000 strb 0xC, then 0x1004 strb 0x7 last.
        run_op(make_op(32'h0000_1002, 32'h0, 1'b0, 1'b0, 2'd0, 5, 0, 2), 0);
        // Strided halfwords with a three-cycle stall on the second beat.
        run_op(make_op(32'h0000_2000, 32'h10, 1'b1, 1'b1, 2'd1, 3, 0, 3), 2);
        // vstart == vl: no traffic, clean completion.
        run_op(make_op(32'h0000_1000, 32'h0, 1'b0, 1'b1, 2'd2, 4, 4, 0), 0);
        // 64-bit elements on a 32-bit port: rejected.
        run_op(make_op(32'h0000_1000, 32'h0, 1'b0, 1'b1, 2'd3, 4, 0, 1), 0);
        // Base not aligned to the element size: rejected.
        run_op(make_op(32'h0000_1001, 32'h0, 1'b0, 1'b1, 2'd2, 4, 0, 2), 0);
        // Address wrap past 2^32.
        run_op(make_op(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 2'd2, 2, 0, 3), 0);
        // Strided with a stride that misaligns the second element.
        run_op(make_op(32'h0000_4000, 32'h6, 1'b1, 1'b0, 2'd2, 4, 0, 0), 0);
        // Unit-stride with nonzero vstart and random stalls.
        run_op(make_op(32'h0000_5002, 32'h0, 1'b0, 1'b0, 2'd1, 9, 3, 1), 1);

        // Reset during the second beat of a four-beat load.
        op = make_op(32'h0000_3000, 32'h0, 1'b0, 1'b1, 2'd2, 4, 0, 1);
        apply_req(op);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("rst_mid_beat1_addr", mem_addr_o, 32'h0000_3000);
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_mid_beat2_valid", mem_valid_o, 1);
        check("rst_mid_beat2_addr", mem_addr_o, 32'h0000_3004);
        mem_ready_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("rst_mid_no_done", done_valid_o, 0);
            check("rst_mid_no_valid", mem_valid_o, 0);
        end
        check("rst_mid_ready", req_ready_o, 1);

        // Randomized operations against the model.
        for (int n = 0; n < 40; n++) begin
            op.ew = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            esz   = 32'd1 << op.ew;
            op.base = $urandom;
            if ($urandom_range(0, 4) != 0) op.base = op.base & ~(esz - 32'd1);
            op.strided = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) op.stride = $urandom;
            else op.stride = (32'($urandom_range(0, 8)) - 32'd4) * esz;
            op.vl = VlWidth'($urandom_range(0, 10));
            if ($urandom_range(0, 4) == 0) op.vstart = VlWidth'($urandom_range(0, 12));
            else op.vstart = VlWidth'($urandom_range(0, int'(op.vl)));
            op.is_load = 1'($urandom_range(0, 1));
            op.id      = IdWidth'($urandom_range(0, 3));
            run_op(op, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spatz_vlsu_addrgen.md
# spatz_vlsu_addrgen

Address/request generator for the Spatz vector load/store unit. Accepts one decoded memory operation (VLE/VSE/VLSE) at a time and converts it into a stream of ELEN-wide memory requests carrying address, byte strobes, size, write-enable, last flag and instruction ID. Sits between the controller's VLSU issue port and the memory request channel. Completes each operation with a one-cycle done/exception pulse to the controller.

## Interface
- ELEN, 32: memory word width in bits; ELENB = ELEN/8.
- MAXVL, 256: maximum vector length in elements; VlWidth = $clog2(MAXVL+1).
- IdWidth, 2: instruction ID width, equal to $clog2(NrParallelInstructions).

- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i / req_ready_o  in/out  1  operation handshake.
- req_id_i  in  IdWidth  instruction ID.
- req_base_i  in  32  base byte address (rs1).
- req_stride_i  in  32  byte stride (rs2), used only when strided.
- req_strided_i  in  1  1 = VLSE/VSSE, 0 = unit-stride.
- req_is_load_i  in  1  1 = load, 0 = store.
- req_ew_i  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- req_vl_i, req_vstart_i  in  VlWidth  vector length and start element.
- mem_valid_o / mem_ready_i  out/in  1  memory request handshake.
- mem_addr_o  out  32  request address.
- mem_we_o  out  1  write enable (= !is_load).
- mem_strb_o  out  ELENB  byte strobes.
- mem_size_o  out  2  log2 bytes of the access.
- mem_last_o  out  1  last request of the operation.
- mem_id_o  out  IdWidth  instruction ID.
- done_valid_o  out  1  one-cycle completion pulse.
- done_id_o  out  IdWidth  completing ID.
- done_exc_o  out  1  operation rejected (no or partial memory traffic).
- busy_o  out  1  state != IDLE.

## Operation
- FSM states IDLE, ISSUE, DONE. req_ready_o = (state == IDLE).
- IDLE, handshake: latch fields; cur_addr = base + vstart·(1<<ew) (unit) or base + vstart·stride (strided); remaining = vl − vstart elements.
  - ew > log2(ELENB), or base not aligned to element size: -> DONE, exc=1.
  - vstart >= vl: -> DONE, exc=0, no memory request.
  - otherwise -> ISSUE.
- ISSUE, unit-stride: off = cur_addr mod ELENB; beat_bytes = min(ELENB − off, remaining<<ew); mem_addr_o = cur_addr aligned down to ELENB; strb bits [off, off+beat_bytes) set; size = log2(ELENB). On handshake: cur_addr += beat_bytes, remaining −= beat_bytes>>ew.
- ISSUE, strided: one element per beat; mem_addr_o = cur_addr; strb = ((1<<(1<<ew))−1) << off; size = ew. On handshake: cur_addr += stride, remaining −= 1. Misaligned element in strided mode flagged at that beat: request suppressed, -> DONE exc=1.
- mem_last_o = 1 on the beat that drives remaining to 0; handshake of that beat -> DONE.
- DONE: done_valid_o=1 for exactly one cycle with done_id_o, done_exc_o; -> IDLE.
- All address arithmetic is modulo 2^32 (wrap, no exception).

## Timing
- Reset: state IDLE; req_ready_o=1; mem_valid_o, mem_last_o, mem_we_o, done_valid_o, done_exc_o, busy_o = 0; mem_addr_o, mem_strb_o, mem_size_o, mem_id_o, done_id_o = 0.
- All mem_* and done_* outputs registered. First mem_valid_o one cycle after request handshake; done_valid_o one cycle after last mem handshake (or after accept for zero-length/rejected ops).
- While mem_valid_o=1 and mem_ready_i=0, all mem_* outputs hold stable; valid never drops before handshake.
- Back-to-back beats: one beat per cycle with mem_ready_i held high.
- New request accepted the cycle after DONE (no overlap).
- rst_ni asserted mid-operation: immediate return to reset values; in-flight operation discarded, no done pulse.

## Configuration
- SPATZ_LSU_STRIDED_EN defined: strided path as above.
- Not defined: strided logic removed; any request with req_strided_i=1 -> DONE exc=1, zero memory requests; unit-stride unchanged.

## Test plan
- Unit-stride load, base=0x1000, ew=2, vl=4, vstart=0 -> 4 beats addr 0x1000/04/08/0C, strb=0xF, size=2, we=0, last on 4th, then done exc=0.
- Unit-stride store, base=0x1002, ew=0, vl=5 -> beats 0x1000 strb=0xC, 0x1004 strb=0x7 last; we=1.
- Strided (macro on), base=0x2000, stride=0x10, ew=1, vl=3 -> addr 0x2000/0x2010/0x2020, strb=0x3, size=1; mem_ready_i low 3 cycles on beat 2 -> outputs held.
- vl=4, vstart=4 -> no mem_valid_o, done_valid_o one cycle after accept, exc=0; ew=3 with ELEN=32 -> done exc=1.
- Macro off, strided request -> done exc=1, no beats; reset asserted during beat 2 of a 4-beat op -> outputs zeroed, req_ready_o=1, no done pulse.
- base=0xFFFFFFFC, ew=2, vl=2 -> addresses 0xFFFFFFFC then 0x00000000, no exception.
